uart_prog_loader: RTL

- On-chip boot loader controller for the user-project core.
- Receives a program over a UART RX line, assembles bytes into 32-bit instruction words and writes them sequentially into instruction memory.
- Detects the end-of-program word 32'h00000FFF, then releases the core from reset.
- Advertises readiness to the external programmer through ready_o, which the programmer polls before it starts sending bytes.

---
 rtl/uart_prog_loader_pkg.sv | 8 +
 rtl/uart_rx.sv | 74 +++++++
 rtl/uart_prog_loader.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_prog_loader_pkg.sv
// uart_prog_loader_pkg: loader and receiver state enums, terminator word, bytes-per-word constants
package uart_prog_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  localparam logic [31:0] TERM_WORD_DEF = 32'h00000FFF;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver; in clk_i, rst_i, rx_i (async, idle high); out rx_valid_o pulse, rx_byte_o, rx_frame_err_o pulse
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_frame_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  rx_state_e st_q, st_d;
  logic s1_q, s2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic valid_d, ferr_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {s1_q, s2_q, prev_q} <= 3'b111;
      st_q <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      rx_valid_o <= 1'b0;
      rx_frame_err_o <= 1'b0;
    end else begin
      {s1_q, s2_q, prev_q} <= {rx_i, s1_q, s2_q};
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      rx_valid_o <= valid_d;
      rx_frame_err_o <= ferr_d;
    end
  end
  // Start is re-checked half a bit after the edge; every later sample is a whole bit on, landing mid-bit.
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    byte_d = byte_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) st_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        st_d = s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        byte_d = {s2_q, byte_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == LAST) begin
        st_d = RX_IDLE;
        valid_d = s2_q;
        ferr_d = !s2_q;
      end
      default: st_d = RX_IDLE;
    endcase
  end
  assign rx_byte_o = byte_q;
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART boot loader; in wb_clk_i, wb_rst_i, load_en_i, uart_rx_i; out ready_o, imem_we_o/addr_o/wdata_o, core_rst_o, done_o, err_o, words_o
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          ADDR_W       = 12,
  parameter logic [31:0] TERM_WORD    = TERM_WORD_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              load_en_i,
  input  logic              uart_rx_i,
  output logic              ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);
  state_e st_q, st_d;
  logic [23:0] sh_q, sh_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [ADDR_W:0] words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, word;
  logic we_q, we_d, err_q, err_d, rx_valid, rx_ferr;
  logic [7:0] rx_byte;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .rx_i(uart_rx_i),
    .rx_valid_o(rx_valid),
    .rx_byte_o(rx_byte),
    .rx_frame_err_o(rx_ferr)
  );
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      st_q <= IDLE;
      sh_q <= '0;
      bcnt_q <= '0;
      words_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      bcnt_q <= bcnt_d;
      words_q <= words_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      err_q <= err_d;
    end
  end
  // words_q never exceeds capacity, so its top bit alone flags a full memory.
  always_comb begin
    st_d = st_q;
    sh_d = sh_q;
    bcnt_d = bcnt_q;
    words_d = words_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    word = {sh_q, rx_byte};
    case (st_q)
      IDLE: st_d = load_en_i ? LOAD : RUN;
      LOAD: begin
        if (rx_ferr) st_d = ERROR;
        else if (rx_valid) begin
          sh_d = word[23:0];
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
            if (word == TERM_WORD) st_d = RUN;
            else if (words_q[ADDR_W]) st_d = ERROR;
            else begin
              we_d = 1'b1;
              addr_d = words_q[ADDR_W-1:0];
              wdata_d = word;
              words_d = words_q + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    err_d = err_q | rx_ferr | (st_d == ERROR);
  end
  assign ready_o = st_q == LOAD;
  assign done_o = st_q == RUN;
  assign core_rst_o = st_q != RUN;
  assign imem_we_o = we_q;
  assign imem_addr_o = addr_q;
  assign imem_wdata_o = wdata_q;
  assign err_o = err_q;
  assign words_o = words_q;
endmodule
